// File: rtl/mixer_pkg.sv
// Shared types and constants for the convolution MAC sequencer.
package mixer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int SAT_MAX   = 127;
  localparam int SAT_MIN   = -128;
  localparam int KSIZE_DEF = 25;
  localparam int ACC_W_DEF = 16;

  // Clip a wide signed value to int8; returns {clipped, value}.
  function automatic logic [8:0] sat_clip8(input logic signed [31:0] v);
    logic [8:0] r;
    if (v > SAT_MAX) begin
      r = {1'b1, 8'h7F};
    end else if (v < SAT_MIN) begin
      r = {1'b1, 8'h80};
    end else begin
      r = {1'b0, v[7:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/mixer_mac_ctrl_if.sv
// Operand stream, result stream and control handshake of the MAC sequencer.
interface mixer_mac_ctrl_if;
  logic              start;
  logic              busy;
  logic              pix_valid;
  logic              pix_ready;
  logic signed [7:0] pix_data;
  logic signed [7:0] wgt_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic              out_sat;

  modport slave (
    input  start, pix_valid, pix_data, wgt_data, out_ready,
    output busy, pix_ready, out_valid, out_data, out_sat
  );

  modport master (
    output start, pix_valid, pix_data, wgt_data, out_ready,
    input  busy, pix_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mixer_pixel.sv
// Signed 8x8 multiplier keeping only the low byte of the product.
module mixer_pixel (
  input  logic signed [7:0] a_i,
  input  logic signed [7:0] b_i,
  output logic signed [7:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

// File: rtl/mixer_mac_ctrl.sv
// Time-shares one mixer_pixel multiplier across a KSIZE-tap window and
// returns one saturated int8 result per window.
module mixer_mac_ctrl
  import mixer_pkg::*;
#(
  parameter int KSIZE = KSIZE_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  mixer_mac_ctrl_if.slave bus
);

  localparam int CNT_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic                     op_vld_q, op_vld_d;
  logic signed [7:0]        opa_q, opa_d;
  logic signed [7:0]        opb_q, opb_d;
  logic signed [7:0]        prod_s;
  logic                     accept_s;
  logic        [8:0]        sat_s;

  mixer_pixel u_mul (
    .a_i (opa_q),
    .b_i (opb_q),
    .p_o (prod_s)
  );

  assign accept_s = (state_q == ST_MAC) && bus.pix_valid;

  // Next-state, accumulate and operand-capture logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_vld_d = op_vld_q;
    opa_d    = opa_q;
    opb_d    = opb_q;

    // The pair captured last cycle is folded in one edge later, hence FLUSH.
    if (op_vld_q && ((state_q == ST_MAC) || (state_q == ST_FLUSH))) begin
      acc_d = acc_q + {{(ACC_W-8){prod_s[7]}}, prod_s};
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_MAC;
          acc_d    = '0;
          cnt_d    = '0;
          op_vld_d = 1'b0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (accept_s) begin
          opa_d    = bus.pix_data;
          opb_d    = bus.wgt_data;
          op_vld_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(KSIZE - 1)) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_MAC;
          end
        end else begin
          op_vld_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        op_vld_d = 1'b0;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        op_vld_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_vld_q <= 1'b0;
      opa_q    <= 8'sd0;
      opb_q    <= 8'sd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_vld_q <= op_vld_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
    end
  end

  // acc only moves in MAC/FLUSH, so the clipped view is stable throughout DONE.
  assign sat_s         = sat_clip8(int'(acc_q));
  assign bus.out_sat   = sat_s[8];
  assign bus.out_data  = sat_s[7:0];
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.pix_ready = (state_q == ST_MAC);
  assign bus.out_valid = (state_q == ST_DONE);

endmodule
